am_gap_idle_adapter: RTL and testbench
======================================

// Module: am_gap_idle_adapter
// PURPOSE
// - Parametrised successor to the fixed idle insertion stage of the 100GbE PCS TX path. Sits between the 64b/8b MII-side block stream and encoder_interface.
// - Every AM_PERIOD output slots, reserves N_LANES consecutive alignment-marker slots (o_am_flag=1).
// - Buffers input blocks in a FIFO and deletes idle blocks to recover the AM gap bandwidth.
// - Inserts idle blocks whenever no data is available, so the output stream is continuous.
// PARAMETERS
// NB_DATA      64     data width per block (multiple of 8)
// NB_CTRL      8      ctrl width, NB_DATA/8, one bit per byte (1 = control char)
// N_LANES      20     AM slots per period
// AM_PERIOD    16384  output slots per AM period, including the AM slots; must be > N_LANES
// FIFO_DEPTH   32     buffer entries, power of 2, >= N_LANES
// NB_LEVEL     6      occupancy width, clog2(FIFO_DEPTH)+1
// PORTS
// i_clock       in   1         single clock
// i_reset       in   1         asynchronous, active-high reset
// i_enable      in   1         0 = freeze all state, o_valid=0
// i_valid       in   1         input block present
// i_tx_data     in   NB_DATA   input block data
// i_tx_ctrl     in   NB_CTRL   input block ctrl
// o_tx_data     out  NB_DATA   output block data
// o_tx_ctrl     out  NB_CTRL   output block ctrl
// o_am_flag     out  1         current slot is an AM slot
// o_valid       out  1         output slot valid
// o_overflow    out  1         sticky: a non-idle block was dropped because the FIFO was full
// o_fifo_level  out  NB_LEVEL  FIFO occupancy
// BEHAVIOUR
// - Reset: all outputs = 0; slot counter = 0; FIFO empty. Takes effect immediately, also mid-operation; in-flight blocks are discarded.
// - Idle block: ctrl all ones, every data byte 8'h07.
// - All outputs are registered; a pass-through block appears one cycle after it is sampled.
// - Slot counter
//   - Advances once per enabled cycle, wrapping from AM_PERIOD-1 to 0.
//   - A slot is an AM slot when the counter < N_LANES, so the first N_LANES slots after reset are AM slots.
// - Per enabled cycle, output source in priority order:
//   1. AM slot: data=0, ctrl=0, o_am_flag=1. The FIFO is not read.
//   2. FIFO non-empty: pop the head block.
//   3. i_valid and input will be output (not deleted): pass input straight through; it is not written to the FIFO.
//   4. Otherwise: emit an idle block (idle insertion).
//   - o_valid=1 in every enabled cycle.
// - Input handling when i_valid=1 and i_enable=1:
//   - Idle deletion: drop the input when it is idle AND (FIFO non-empty OR AM slot).
//   - Otherwise, if the input is not passed through, write it to the FIFO.
//   - FIFO full and no pop this cycle: drop the block and set o_overflow. An idle block dropped this way does not set o_overflow.
//   - Pop and push in the same cycle when full: the push is allowed; level is unchanged.
// - Ordering: blocks leave in arrival order. Pass-through is legal only when the FIFO is empty.
// - o_fifo_level: registered occupancy after this cycle's push/pop, range 0..FIFO_DEPTH.
// - i_enable=0: counter, FIFO and output data held; o_valid=0; input ignored.
// - o_overflow clears only on reset.
// TESTING (AM_PERIOD=100, N_LANES=20, FIFO_DEPTH=32)
// - Reset, then continuous idle input:
//   - slots 0-19 have am_flag=1 with data=0; slots 20-99 are idle blocks; repeats at slot 100.
//   - o_fifo_level stays 0; o_valid=1 throughout.
// - Burst of 30 data blocks starting at slot 0, then continuous idle:
//   - data blocks out at slots 20-49, in order.
//   - peak level 20; idles deleted while non-empty; level 0 by slot 50.
// - Continuous non-idle data:
//   - level climbs to 20 at slot 20 and holds.
//   - at the slot-100 AM gap it reaches 32; the first drop sets o_overflow=1 sticky.
// - i_valid=0 for 10 cycles mid-period with the FIFO empty: 10 idle blocks inserted, o_valid stays 1, am_flag=0.
// - Full FIFO with simultaneous pop and non-idle push: level stays 32, no overflow, order preserved.
// - Reset asserted at slot 10 with level 5:
//   - outputs go to 0 without waiting for a clock edge.
//   - after release, slot 0 is an AM slot and level=0.

Source files
------------

// File: rtl/am_gap_idle_adapter.sv
// ---------------------------------------------------------------------------
// am_gap_idle_adapter
//
// Purpose:
//   Idle insertion / deletion stage for the PCS TX path, placed between the
//   MII-side block stream and the encoder interface. Every AM_PERIOD output
//   slots it reserves N_LANES consecutive alignment-marker slots. Blocks that
//   arrive while a marker slot is being emitted (or while older blocks are
//   still waiting) are buffered in a small FIFO. Idle blocks are deleted when
//   the FIFO holds data, which recovers the bandwidth lost to the marker gap.
//   Idle blocks are inserted whenever there is nothing to send, so the output
//   stream never has holes.
//
// Ports:
//   i_clock       single clock
//   i_reset       asynchronous, active-high reset
//   i_enable      0 = hold all state, o_valid = 0
//   i_valid       input block present
//   i_tx_data     input block data  (NB_DATA bits)
//   i_tx_ctrl     input block ctrl  (NB_CTRL bits, 1 = control byte)
//   o_tx_data     output block data
//   o_tx_ctrl     output block ctrl
//   o_am_flag     current output slot is an alignment-marker slot
//   o_valid       output slot valid (1 in every enabled cycle)
//   o_overflow    sticky: a non-idle block was dropped on a full FIFO
//   o_fifo_level  FIFO occupancy after this cycle's push/pop
// ---------------------------------------------------------------------------
module am_gap_idle_adapter #(
    parameter int NB_DATA    = 64,
    parameter int NB_CTRL    = NB_DATA / 8,
    parameter int N_LANES    = 20,
    parameter int AM_PERIOD  = 16384,
    parameter int FIFO_DEPTH = 32,
    parameter int NB_LEVEL   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_tx_data,
    input  logic [NB_CTRL-1:0]  i_tx_ctrl,
    output logic [NB_DATA-1:0]  o_tx_data,
    output logic [NB_CTRL-1:0]  o_tx_ctrl,
    output logic                o_am_flag,
    output logic                o_valid,
    output logic                o_overflow,
    output logic [NB_LEVEL-1:0] o_fifo_level
);

    localparam int NB_PTR  = $clog2(FIFO_DEPTH);
    localparam int NB_SLOT = $clog2(AM_PERIOD);
    localparam int NB_WORD = NB_CTRL + NB_DATA;

    localparam logic [NB_DATA-1:0] IDLE_DATA = {(NB_DATA / 8){8'h07}};
    localparam logic [NB_CTRL-1:0] IDLE_CTRL = '1;

    // Output slot counter and FIFO state
    logic [NB_SLOT-1:0]  slot;
    logic [NB_PTR-1:0]   wr_ptr;
    logic [NB_PTR-1:0]   rd_ptr;
    logic [NB_LEVEL-1:0] level;
    logic [NB_WORD-1:0]  mem [FIFO_DEPTH];

    // Per-cycle decisions
    logic                is_am;
    logic                in_idle;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                pass;
    logic                del;
    logic                want_push;
    logic                push;
    logic                drop;
    logic [NB_WORD-1:0]  head;
    logic [NB_SLOT-1:0]  slot_next;
    logic [NB_LEVEL-1:0] level_next;
    logic                am_next;
    logic [NB_DATA-1:0]  data_next;
    logic [NB_CTRL-1:0]  ctrl_next;

    assign head         = mem[rd_ptr];
    assign o_fifo_level = level;

    // Slot classification and the push/pop/pass decisions.
    // Pass-through only happens with an empty FIFO so that arrival order is
    // preserved. An idle input is deleted whenever it would otherwise have to
    // queue (FIFO busy or marker slot), so idles never occupy FIFO entries.
    always_comb begin
        is_am      = (slot < NB_SLOT'(N_LANES));
        in_idle    = (i_tx_ctrl == IDLE_CTRL) && (i_tx_data == IDLE_DATA);
        fifo_empty = (level == '0);
        fifo_full  = (level == NB_LEVEL'(FIFO_DEPTH));
        pop        = !is_am && !fifo_empty;
        pass       = !is_am && fifo_empty && i_valid;
        del        = i_valid && in_idle && (!fifo_empty || is_am);
        want_push  = i_valid && !del && !pass;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts
        push       = want_push && (!fifo_full || pop);
        drop       = want_push && fifo_full && !pop;
    end

    // Next output block, in priority order: marker, FIFO head, pass-through,
    // inserted idle.
    always_comb begin
        am_next   = 1'b0;
        data_next = IDLE_DATA;
        ctrl_next = IDLE_CTRL;
        if (is_am) begin
            am_next   = 1'b1;
            data_next = '0;
            ctrl_next = '0;
        end else if (pop) begin
            data_next = head[NB_DATA-1:0];
            ctrl_next = head[NB_WORD-1:NB_DATA];
        end else if (pass) begin
            data_next = i_tx_data;
            ctrl_next = i_tx_ctrl;
        end
    end

    // Counter wrap and occupancy bookkeeping
    always_comb begin
        slot_next = (slot == NB_SLOT'(AM_PERIOD - 1)) ? '0 : slot + NB_SLOT'(1);
        level_next = level;
        if (push && !pop) begin
            level_next = level + NB_LEVEL'(1);
        end else if (pop && !push) begin
            level_next = level - NB_LEVEL'(1);
        end
    end

    // Control state and registered outputs. Disabled cycles only drop o_valid.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            slot       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            o_tx_data  <= '0;
            o_tx_ctrl  <= '0;
            o_am_flag  <= 1'b0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_enable) begin
            slot      <= slot_next;
            level     <= level_next;
            o_tx_data <= data_next;
            o_tx_ctrl <= ctrl_next;
            o_am_flag <= am_next;
            o_valid   <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + NB_PTR'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + NB_PTR'(1);
            end
            // Dropped idles carry no information, so they are not an overflow
            if (drop && !in_idle) begin
                o_overflow <= 1'b1;
            end
        end else begin
            o_valid <= 1'b0;
        end
    end

    // FIFO storage has no reset; the pointers alone define its contents
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_enable && push) begin
            mem[wr_ptr] <= {i_tx_ctrl, i_tx_data};
        end
    end

endmodule

// File: tb/tb_am_gap_idle_adapter.sv
// ---------------------------------------------------------------------------
// tb_am_gap_idle_adapter
//
// Purpose:
//   Self-checking bench for am_gap_idle_adapter (AM_PERIOD=100, N_LANES=20,
//   FIFO_DEPTH=32). Stimulus drives inputs on the falling edge and feeds a
//   reference model (a block queue plus a slot number) that pushes the
//   expected output of each slot into a scoreboard. An independent monitor
//   samples the DUT just after each rising edge and pops/compares.
// ---------------------------------------------------------------------------
module tb_am_gap_idle_adapter;

    localparam int NB_DATA    = 64;
    localparam int NB_CTRL    = 8;
    localparam int N_LANES    = 20;
    localparam int AM_PERIOD  = 100;
    localparam int FIFO_DEPTH = 32;
    localparam int NB_LEVEL   = 6;

    localparam logic [63:0] IDLE_D = 64'h0707_0707_0707_0707;
    localparam logic [7:0]  IDLE_C = 8'hFF;

    logic                clock = 1'b0;
    logic                reset;
    logic                enable;
    logic                valid;
    logic [NB_DATA-1:0]  tx_data;
    logic [NB_CTRL-1:0]  tx_ctrl;
    logic [NB_DATA-1:0]  out_data;
    logic [NB_CTRL-1:0]  out_ctrl;
    logic                out_am;
    logic                out_valid;
    logic                out_overflow;
    logic [NB_LEVEL-1:0] out_level;

    always #5 clock = ~clock;

    am_gap_idle_adapter #(
        .NB_DATA   (NB_DATA),
        .NB_CTRL   (NB_CTRL),
        .N_LANES   (N_LANES),
        .AM_PERIOD (AM_PERIOD),
        .FIFO_DEPTH(FIFO_DEPTH),
        .NB_LEVEL  (NB_LEVEL)
    ) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_valid     (valid),
        .i_tx_data   (tx_data),
        .i_tx_ctrl   (tx_ctrl),
        .o_tx_data   (out_data),
        .o_tx_ctrl   (out_ctrl),
        .o_am_flag   (out_am),
        .o_valid     (out_valid),
        .o_overflow  (out_overflow),
        .o_fifo_level(out_level)
    );

    typedef struct packed {
        logic        am;
        logic [63:0] data;
        logic [7:0]  ctrl;
        logic [5:0]  level;
        logic        ovf;
    } exp_t;

    exp_t        exp_q[$];
    bit          valid_q[$];
    logic [71:0] model_fifo[$];
    int          model_slot;
    bit          model_ovf;
    int          compared;
    int          mismatched;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] want);
        compared++;
        if (act !== want) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
        end
    endtask

    // Reference model: one enabled output slot, described directly in terms
    // of marker slots, a block queue, idle deletion and idle insertion.
    task automatic model_step(input bit v, input logic [63:0] d, input logic [7:0] c);
        exp_t        e;
        bit          am;
        bit          idle;
        bit          taken;
        int          size0;
        logic [71:0] blk;
        am    = (model_slot < N_LANES);
        idle  = (c == IDLE_C) && (d == IDLE_D);
        size0 = model_fifo.size();
        taken = 1'b0;
        e.am  = am;
        if (am) begin
            e.data = '0;
            e.ctrl = '0;
        end else if (size0 > 0) begin
            blk    = model_fifo.pop_front();
            e.ctrl = blk[71:64];
            e.data = blk[63:0];
        end else if (v) begin
            e.data = d;
            e.ctrl = c;
            taken  = 1'b1;
        end else begin
            e.data = IDLE_D;
            e.ctrl = IDLE_C;
        end
        if (v && !taken && !(idle && (size0 > 0 || am))) begin
            if (model_fifo.size() < FIFO_DEPTH) begin
                model_fifo.push_back({c, d});
            end else if (!idle) begin
                model_ovf = 1'b1;
            end
        end
        e.level = 6'(model_fifo.size());
        e.ovf   = model_ovf;
        exp_q.push_back(e);
        model_slot = (model_slot + 1) % AM_PERIOD;
    endtask

    task automatic apply_stimulus(input bit en, input bit v, input logic [63:0] d, input logic [7:0] c);
        @(negedge clock);
        enable  = en;
        valid   = v;
        tx_data = d;
        tx_ctrl = c;
        valid_q.push_back(en);
        if (en) begin
            model_step(v, d, c);
        end
    endtask

    // Reset asserted mid-cycle; outputs must clear without a clock edge
    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset  = 1'b1;
        enable = 1'b0;
        valid  = 1'b0;
        #1;
        check_output("rst_valid", 64'(out_valid), 64'd0);
        check_output("rst_data", out_data, 64'd0);
        check_output("rst_ctrl", 64'(out_ctrl), 64'd0);
        check_output("rst_am", 64'(out_am), 64'd0);
        check_output("rst_ovf", 64'(out_overflow), 64'd0);
        check_output("rst_level", 64'(out_level), 64'd0);
        valid_q.delete();
        exp_q.delete();
        model_fifo.delete();
        model_slot = 0;
        model_ovf  = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_data();
        apply_stimulus(1'b1, 1'b1, {$urandom, $urandom}, 8'($urandom));
    endtask

    task automatic send_idle();
        apply_stimulus(1'b1, 1'b1, IDLE_D, IDLE_C);
    endtask

    // Monitor: compares every DUT slot against the scoreboard head
    initial begin : monitor
        exp_t e;
        bit   ev;
        forever begin
            @(posedge clock);
            #1;
            if (valid_q.size() > 0) begin
                ev = valid_q.pop_front();
                check_output("valid", 64'(out_valid), 64'(ev));
                if (ev && out_valid) begin
                    if (exp_q.size() == 0) begin
                        check_output("exp_queue_empty", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("am_flag", 64'(out_am), 64'(e.am));
                        check_output("data", out_data, e.data);
                        check_output("ctrl", 64'(out_ctrl), 64'(e.ctrl));
                        check_output("level", 64'(out_level), 64'(e.level));
                        check_output("overflow", 64'(out_overflow), 64'(e.ovf));
                    end
                end else if (ev && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                end
            end else if (out_valid && !reset) begin
                check_output("unexpected_valid", 64'(out_valid), 64'd0);
            end
        end
    end

    initial begin : stimulus
        compared   = 0;
        mismatched = 0;
        model_slot = 0;
        model_ovf  = 1'b0;
        reset      = 1'b1;
        enable     = 1'b0;
        valid      = 1'b0;
        tx_data    = '0;
        tx_ctrl    = '0;
        apply_reset();

        // Continuous idle over more than one period, then an input gap
        for (int i = 0; i < 150; i++) send_idle();
        for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, {$urandom, $urandom}, 8'($urandom));
        for (int i = 0; i < 5; i++) send_idle();

        // Burst of 30 data blocks from slot 0, then idles
        apply_reset();
        for (int i = 0; i < 30; i++) send_data();
        for (int i = 0; i < 40; i++) send_idle();

        // Continuous data: fills at the second marker gap, overflows, full pop+push
        apply_reset();
        for (int i = 0; i < 200; i++) send_data();

        // Build level 5 during the marker slots, reset at slot 10
        apply_reset();
        for (int i = 0; i < 5; i++) send_data();
        for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, '0, '0);
        @(posedge clock);
        #2;
        check_output("pre_reset_level", 64'(out_level), 64'd5);
        apply_reset();

        // Randomized traffic with enable gaps
        for (int i = 0; i < 400; i++) begin
            bit en;
            bit v;
            en = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                apply_stimulus(en, v, IDLE_D, IDLE_C);
            end else begin
                apply_stimulus(en, v, {$urandom, $urandom}, 8'($urandom));
            end
        end

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, '0, '0);
        @(posedge clock);
        #3;
        check_output("drain", 64'(valid_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
